// File: rtl/regbank_pkg.sv
// Shared types and helpers for the burst-access register bank.
package regbank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RBURST = 2'd2
  } state_t;

  // Address width for n registers; never narrower than one bit.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/regbank_store.sv
// Register array: host write port (wins on collision), core write port,
// combinational core read port, registered host read port.
module regbank_store
  import regbank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_waddr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              col
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              c_in;
  logic              c_act;

  // Core side only acts on in-range addresses; host always targets a valid ptr.
  always_comb begin
    c_in    = ({1'b0, c_addr} < DEPTH_L);
    col     = h_we && c_we && (h_waddr == c_addr);
    c_act   = c_we && c_in && !col;
    c_rdata = c_in ? mem[c_addr] : '0;
  end

  // Array update plus registered read; read samples pre-write contents.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      r_data <= '0;
    end else begin
      if (c_act) mem[c_addr]  <= c_wdata;
      if (h_we)  mem[h_waddr] <= h_wdata;
      if (r_en)  r_data       <= mem[r_addr];
    end
  end

endmodule

// File: rtl/regbank_burst.sv
// Register bank with a burst-oriented host port and a simple core port.
// Host opens a burst (write or read), streams beats through an
// auto-incrementing wrapping pointer, and closes it with h_stop.
module regbank_burst
  import regbank_pkg::*;
#(
  parameter int               DATA_W  = 8,
  parameter int               DEPTH   = 32,
  parameter logic [DEPTH-1:0] RO_MASK = '0,
  localparam int              ADDR_W  = clog2_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              h_start,
  input  logic              h_wr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic              h_valid,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              h_stop,
  output logic              h_ready,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_rvalid,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              c_we,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              err_clr,
  output logic              err_ro,
  output logic              err_col
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic              addr_in;
  logic              wr_beat;
  logic              ro_hit;
  logic              h_we;
  logic              rd_en;
  logic              col;

  // Beat decode: RO beats are dropped but still advance the pointer.
  always_comb begin
    ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;
    addr_in = ({1'b0, h_addr} < DEPTH_L);
    wr_beat = (state == WBURST) && h_valid;
    ro_hit  = wr_beat && RO_MASK[ptr];
    h_we    = wr_beat && !RO_MASK[ptr];
    rd_en   = (state == RBURST) && h_valid;
  end

  regbank_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk     (clk),
    .rstb    (rstb),
    .h_we    (h_we),
    .h_waddr (ptr),
    .h_wdata (h_wdata),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_rdata (c_rdata),
    .r_en    (rd_en),
    .r_addr  (ptr),
    .r_data  (h_rdata),
    .col     (col)
  );

  // Burst FSM with pointer, read-valid pulse and sticky errors (set beats clear).
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      ptr      <= '0;
      h_ready  <= 1'b0;
      h_rvalid <= 1'b0;
      err_ro   <= 1'b0;
      err_col  <= 1'b0;
    end else begin
      h_rvalid <= rd_en;
      err_ro   <= ro_hit | (err_ro  & ~err_clr);
      err_col  <= col    | (err_col & ~err_clr);
      case (state)
        IDLE: begin
          if (h_start) begin
            ptr     <= addr_in ? h_addr : '0;
            state   <= h_wr ? WBURST : RBURST;
            h_ready <= 1'b1;
          end
        end
        WBURST, RBURST: begin
          if (h_valid) ptr <= ptr_nxt;
          if (h_stop) begin
            state   <= IDLE;
            h_ready <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          h_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/regbank_burst.md
REGBANK_BURST -- requirements
Module: regbank_burst

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning register width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning register count (any value 2..256, not necessarily a power of two).
REQ-003 The block SHALL have parameter RO_MASK, default all-zero, DEPTH bits, meaning bit i set makes register i read-only from the host port.
REQ-004 The block SHALL have derived localparam ADDR_W = clog2(DEPTH).
REQ-005 The block SHALL have ports: clk  in  1  clock; rstb  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have ports: h_start  in  1  burst open strobe; h_wr  in  1  burst direction, 1=write; h_addr  in  ADDR_W  burst start address.
REQ-007 The block SHALL have ports: h_valid  in  1  beat request; h_wdata  in  DATA_W  write beat data; h_stop  in  1  burst close strobe.
REQ-008 The block SHALL have ports: h_ready  out  1  burst open; h_rdata  out  DATA_W  read beat data; h_rvalid  out  1  read beat data valid.
REQ-009 The block SHALL have ports: c_addr  in  ADDR_W  core address; c_we  in  1  core write enable; c_wdata  in  DATA_W  core write data; c_rdata  out  DATA_W  core read data.
REQ-010 The block SHALL have ports: err_clr  in  1  clear sticky errors; err_ro  out  1  sticky RO-write error; err_col  out  1  sticky collision error.

Function
REQ-011 The FSM SHALL have states IDLE, WBURST and RBURST; h_ready SHALL be 1 only in WBURST and RBURST.
REQ-012 In IDLE, h_start SHALL load ptr<=h_addr (if h_addr>=DEPTH, ptr<=0) and move to WBURST if h_wr=1, else RBURST; h_start outside IDLE SHALL be ignored.
REQ-013 In WBURST, each cycle with h_valid=1 SHALL write h_wdata to reg[ptr] and increment ptr.
REQ-014 ptr SHALL wrap from DEPTH-1 to 0.
REQ-015 A WBURST beat to an address with RO_MASK bit set SHALL be dropped, still increment ptr, and set err_ro.
REQ-016 In RBURST, each cycle with h_valid=1 SHALL register h_rdata<=reg[ptr] and pulse h_rvalid for exactly one cycle, one cycle after the request (latency 1), and increment ptr; h_rdata SHALL hold its value between beats.
REQ-017 A host read SHALL return the array contents before any write in the same cycle.
REQ-018 h_stop SHALL return the FSM to IDLE on the next edge; h_stop together with h_valid SHALL complete that beat first; h_valid in IDLE SHALL be ignored.
REQ-019 The core port SHALL read combinationally: c_rdata=reg[c_addr], and 0 when c_addr>=DEPTH.
REQ-020 The core port SHALL write reg[c_addr]<=c_wdata on c_we; core writes SHALL ignore RO_MASK, and writes with c_addr>=DEPTH SHALL be ignored.
REQ-021 If a host write and a core write target the same address in the same cycle, the host data SHALL win and err_col SHALL be set; writes to different addresses SHALL both take effect.
REQ-022 err_clr SHALL clear both sticky errors; a set in the same cycle SHALL take priority over the clear.

Reset
REQ-023 rstb low SHALL asynchronously force: all registers 0, ptr 0, state IDLE, h_rdata 0, h_rvalid 0, err_ro 0, err_col 0.
REQ-024 Reset mid-burst SHALL abort the burst; the first cycle after release SHALL be IDLE with h_ready=0.

Structure
REQ-025 Package regbank_pkg SHALL hold the FSM state enum and the clog2-based address-width helper function.
REQ-026 Storage SHALL be one sub-module, regbank_store: a DEPTH x DATA_W array with a host write port, a core write port with host priority and collision flag, one combinational read port and one registered read port.

Verification
REQ-027 The bench SHALL cover: reset, then c_addr=5 -> c_rdata=0x00; h_ready=0; err_ro=0; err_col=0.
REQ-028 The bench SHALL cover: h_start with h_wr=1 and h_addr=30, then 4 beats AA,BB,CC,DD, then h_stop -> reg30=AA, reg31=BB, reg0=CC, reg1=DD (wrap); then IDLE.
REQ-029 The bench SHALL cover: read burst from addr 30 with 3 back-to-back beats -> h_rvalid high for 3 cycles, each 1 cycle after its request, h_rdata=AA,BB,CC.
REQ-030 The bench SHALL cover: RO_MASK bit 2 set, host write 0x55 to addr 2 -> reg2 unchanged, err_ro=1; err_clr -> err_ro=0.
REQ-031 The bench SHALL cover: same-cycle host write 0x11 and core write 0x22 to addr 7 -> reg7=0x11, err_col=1; same test on addrs 7 and 8 -> both written, err_col unchanged.
REQ-032 The bench SHALL cover: rstb pulsed low mid write burst -> all registers 0 and state IDLE; with DEPTH=20, a burst started at addr 19 wraps to addr 0.
